traffic_ctrl_param: RTL and testbench
=====================================

# traffic_ctrl_param

Parametrised highway/farm-road traffic-light controller; successor to the fixed-delay `trafficlights` block. All dwell times are parameters. Adds a guaranteed minimum highway green, a maximum farm green with a timeout pulse, and a visible state output. It sits between the farm-road vehicle sensor and the two signal-head drivers and runs on the single system clock.

## Interface
- `Y2R_DELAY`, default 3: cycles spent in each yellow state (highway or farm), ≥1.
- `R2G_DELAY`, default 2: cycles spent in the all-red state before farm green, ≥1.
- `MIN_MAIN_GREEN`, default 8: minimum cycles of highway green per visit, ≥1.
- `MAX_SIDE_GREEN`, default 6: maximum cycles of farm green per visit, ≥1.
- `CNT_W`, default 4: dwell counter width. All four delays must be ≤ 2^CNT_W. Elaboration fails otherwise.
- `clk`  in  1  system clock; all state changes occur on its rising edge.
- `clear`  in  1  reset: synchronous, active-high.
- `x`  in  1  farm-road car sensor; 1 means a car is waiting or present.
- `highway`  out  2  highway light: RED=2'd0, YELLOW=2'd1, GREEN=2'd2.
- `farm`  out  2  farm-road light, same encoding.
- `state`  out  3  current state code, S0..S4 = 3'd0..3'd4.
- `side_timeout`  out  1  one-cycle pulse when farm green is ended by `MAX_SIDE_GREEN`.

## Operation
- **Moore FSM.**
  - `highway`/`farm` decode only from the state register.
  - `side_timeout` is a registered flag.
- **States** (highway/farm):
  - S0 GREEN/RED
  - S1 YELLOW/RED
  - S2 RED/RED
  - S3 RED/GREEN
  - S4 RED/YELLOW
- **Dwell counter `cnt`.**
  - Cleared to 0 on every state change.
  - Increments by 1 each cycle the state holds.
  - Saturates at 2^CNT_W−1 and never wraps.
- **Transitions**, evaluated at each rising edge with `clear`=0:
  - S0→S1 when `x`=1 and `cnt` ≥ MIN_MAIN_GREEN−1. Otherwise stay in S0.
  - S1→S2 when `cnt` == Y2R_DELAY−1.
  - S2→S3 when `cnt` == R2G_DELAY−1.
  - S3→S4 when `x`=0, or when `cnt` == MAX_SIDE_GREEN−1. If both conditions hold on the same edge, the exit counts as a normal (sensor) exit.
  - S4→S0 when `cnt` == Y2R_DELAY−1.
- **`side_timeout` rule.** Set to 1 on the edge of an S3→S4 transition only when `x`=1 and `cnt` == MAX_SIDE_GREEN−1. Cleared on every other edge.
- **Sensor handling.**
  - `x` is ignored in S1, S2 and S4.
  - `x` dropping during S1/S2 does not abort the sequence. S3 is still entered and lasts 1 cycle if `x`=0 at its first edge.
  - After S4→S0, S0 again requires MIN_MAIN_GREEN cycles before serving `x`, even if `x` stayed high.
- **Reset.** `clear`=1 at a rising edge forces:
  - state S0, `cnt`=0
  - `highway`=GREEN, `farm`=RED
  - `side_timeout`=0

  `clear` overrides every transition, including mid-sequence.
- **Safety invariant.** `highway` and `farm` are never both non-RED.

## Timing
- Output latency: lights change in the same cycle the state register changes, with no extra pipeline stage.
- Exact dwell times: S1 = Y2R_DELAY cycles, S2 = R2G_DELAY cycles, S4 = Y2R_DELAY cycles.
- S0 dwell: at least MIN_MAIN_GREEN cycles. If `x` is continuously high, exactly MIN_MAIN_GREEN cycles.
- S3 dwell: 1..MAX_SIDE_GREEN cycles.
- `side_timeout` is high for exactly the first cycle of S4 following a timeout exit.
- `x` is sampled only at rising edges. No synchroniser is inside the block; the caller provides a synchronous `x`.
- After `clear` deasserts, S0 `cnt` starts at 0 on the first non-clear edge.

## Test plan
- **Idle after reset.** `clear`=1 for 5 negedges, then `x`=0 for 50 cycles → `highway`=2, `farm`=0, `state`=0, `side_timeout`=0 throughout.
- **Minimum highway green.** `x`=1 immediately after `clear` release, held high, default parameters → exact sequence:
  - 8 cycles highway GREEN
  - 3 cycles highway YELLOW
  - 2 cycles all-RED
  - 6 cycles farm GREEN
  - `side_timeout`=1 for the first S4 cycle
  - 3 cycles farm YELLOW
  - then highway GREEN for 8 cycles before the next S1
- **Early sensor release.** `x`=1 at cycle 20 after reset, dropped on the second S3 cycle (sampled 0 at the edge ending that cycle) → farm GREEN lasts exactly 2 cycles, then 3 cycles farm YELLOW, `side_timeout` stays 0, return to S0.
- **Sensor drop in all-red.** `x`=1 long enough to reach S2, then `x`=0 → S3 is entered for 1 cycle, followed by S4 for 3 cycles, no timeout pulse.
- **Reset mid-operation.** `clear`=1 for one edge while in S2 (and separately while in S3 with `x`=1) → next cycle `state`=0, `highway`=2, `farm`=0, `side_timeout`=0. The new S0 lasts 8 cycles before S1.
- **Minimal parameters.** Instance with all delays = 1, `CNT_W`=1, `x`=1 held → states cycle S0,S1,S2,S3,S4 one cycle each, `side_timeout` pulses every 5th cycle, and the safety invariant is asserted every cycle.

Source files
------------

// File: rtl/traffic_ctrl_param.sv
// Highway/farm-road traffic-light controller with parametrised dwell times,
// a guaranteed minimum highway green and a capped farm green with timeout pulse.
//
// state | meaning
// S0    | highway GREEN, farm RED    (held >= MIN_MAIN_GREEN, leaves on x)
// S1    | highway YELLOW, farm RED   (Y2R_DELAY cycles)
// S2    | all RED                    (R2G_DELAY cycles)
// S3    | highway RED, farm GREEN    (until x drops or MAX_SIDE_GREEN)
// S4    | highway RED, farm YELLOW   (Y2R_DELAY cycles)
module traffic_ctrl_param #(
    parameter int Y2R_DELAY      = 3,
    parameter int R2G_DELAY      = 2,
    parameter int MIN_MAIN_GREEN = 8,
    parameter int MAX_SIDE_GREEN = 6,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       x,
    output logic [1:0] highway,
    output logic [1:0] farm,
    output logic [2:0] state,
    output logic       side_timeout
);

    localparam int CNT_SPAN = 1 << CNT_W;

    if (Y2R_DELAY < 1 || Y2R_DELAY > CNT_SPAN ||
        R2G_DELAY < 1 || R2G_DELAY > CNT_SPAN ||
        MIN_MAIN_GREEN < 1 || MIN_MAIN_GREEN > CNT_SPAN ||
        MAX_SIDE_GREEN < 1 || MAX_SIDE_GREEN > CNT_SPAN) begin : g_bad_params
        $error("traffic_ctrl_param: every delay must be in 1..2**CNT_W");
    end

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    // Terminal-count values: cnt holds (cycles already spent in the state) - 1 at each edge.
    localparam logic [CNT_W-1:0] Y2R_LAST = CNT_W'(Y2R_DELAY - 1);
    localparam logic [CNT_W-1:0] R2G_LAST = CNT_W'(R2G_DELAY - 1);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_MAIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_SIDE_GREEN - 1);

    state_t           cur;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    always_comb begin
        nxt         = cur;
        timeout_hit = 1'b0;
        case (cur)
            S0: if (x && cnt >= MIN_LAST) nxt = S1;
            S1: if (cnt == Y2R_LAST) nxt = S2;
            S2: if (cnt == R2G_LAST) nxt = S3;
            S3: begin
                // A simultaneous sensor drop wins over the cap, so no pulse then.
                if (!x || cnt == MAX_LAST) begin
                    nxt         = S4;
                    timeout_hit = x;
                end
            end
            S4: if (cnt == Y2R_LAST) nxt = S0;
            default: nxt = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cur          <= S0;
            cnt          <= '0;
            highway      <= GREEN;
            farm         <= RED;
            side_timeout <= 1'b0;
        end else begin
            cur          <= nxt;
            side_timeout <= timeout_hit;
            if (nxt != cur) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            // Lights are registered from the next state so they track the state register exactly.
            case (nxt)
                S0:      begin highway <= GREEN;  farm <= RED;    end
                S1:      begin highway <= YELLOW; farm <= RED;    end
                S2:      begin highway <= RED;    farm <= RED;    end
                S3:      begin highway <= RED;    farm <= GREEN;  end
                S4:      begin highway <= RED;    farm <= YELLOW; end
                default: begin highway <= RED;    farm <= RED;    end
            endcase
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param: default instance checked against a phase/elapsed-time
// model plus directed sequences; a minimal-parameter instance runs alongside with x held high.
module tb_traffic_ctrl_param;

    localparam int MIN = 8;
    localparam int Y2R = 3;
    localparam int R2G = 2;
    localparam int MAX = 6;

    logic       clk = 1'b0;
    logic       clear, x, clear_m, x_m;
    logic [1:0] highway, farm, highway_m, farm_m;
    logic [2:0] state, state_m;
    logic       side_timeout, side_timeout_m;

    always #5 clk = ~clk;

    traffic_ctrl_param #(
        .Y2R_DELAY(Y2R), .R2G_DELAY(R2G), .MIN_MAIN_GREEN(MIN), .MAX_SIDE_GREEN(MAX), .CNT_W(4)
    ) dut (
        .clk(clk), .clear(clear), .x(x), .highway(highway), .farm(farm),
        .state(state), .side_timeout(side_timeout)
    );

    traffic_ctrl_param #(
        .Y2R_DELAY(1), .R2G_DELAY(1), .MIN_MAIN_GREEN(1), .MAX_SIDE_GREEN(1), .CNT_W(1)
    ) dut_min (
        .clk(clk), .clear(clear_m), .x(x_m), .highway(highway_m), .farm(farm_m),
        .state(state_m), .side_timeout(side_timeout_m)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: current phase, cycles already spent in it, pending pulse.
    int   m_ph = 0;
    int   m_t  = 0;
    logic m_to = 1'b0;
    int   m_k  = 0;
    int   hw_tab[5]   = '{2, 1, 0, 0, 0};
    int   farm_tab[5] = '{0, 0, 0, 2, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic xv, input logic clr);
        int  el;
        bit  leave;
        if (clr) begin
            m_ph = 0; m_t = 0; m_to = 1'b0;
        end else begin
            el    = m_t + 1;
            m_to  = 1'b0;
            leave = 1'b0;
            case (m_ph)
                0: leave = xv && (el >= MIN);
                1: leave = (el == Y2R);
                2: leave = (el == R2G);
                3: begin
                    leave = !xv || (el == MAX);
                    m_to  = xv && (el == MAX);
                end
                default: leave = (el == Y2R);
            endcase
            if (leave) begin
                m_ph = (m_ph + 1) % 5;
                m_t  = 0;
            end else begin
                m_t = el;
            end
        end
    endtask

    task automatic step(input logic xv, input logic clr);
        x     = xv;
        clear = clr;
        @(posedge clk);
        model(xv, clr);
        if (clear_m) m_k = 0; else m_k++;
        @(negedge clk);
        chk("state", state, m_ph);
        chk("highway", highway, hw_tab[m_ph]);
        chk("farm", farm, farm_tab[m_ph]);
        chk("side_timeout", side_timeout, m_to);
        chk("safety", (highway != 2'd0 && farm != 2'd0), 0);
        chk("min_state", state_m, m_k % 5);
        chk("min_highway", highway_m, hw_tab[m_k % 5]);
        chk("min_farm", farm_m, farm_tab[m_k % 5]);
        chk("min_timeout", side_timeout_m, (m_k % 5) == 4);
        chk("min_safety", (highway_m != 2'd0 && farm_m != 2'd0), 0);
    endtask

    task automatic run_until(input int target, input logic xv, input string tag);
        int n = 0;
        while (state !== 3'(target) && n < 60) begin
            step(xv, 1'b0);
            n++;
        end
        chk(tag, state, target);
    endtask

    int exp_seq[31];
    int seg_len[6] = '{8, 3, 2, 6, 3, 8};
    int seg_st[6]  = '{0, 1, 2, 3, 4, 0};

    initial begin
        int idx, n0, n3, nto;
        logic xr;
        clear   = 1'b1;
        x       = 1'b0;
        clear_m = 1'b1;
        x_m     = 1'b1;
        @(negedge clk);

        // Idle after reset
        repeat (5) step(1'b0, 1'b1);
        clear_m = 1'b0;
        repeat (50) step(1'b0, 1'b0);
        chk("idle_state", state, 0);

        // Minimum highway green with x held: compare against a fixed state sequence
        idx = 0;
        for (int s = 0; s < 6; s++)
            for (int j = 0; j < seg_len[s]; j++) begin
                exp_seq[idx] = seg_st[s];
                idx++;
            end
        exp_seq[30] = 1;
        step(1'b1, 1'b1);
        chk("seq_0", state, exp_seq[0]);
        for (int i = 1; i < 31; i++) begin
            step(1'b1, 1'b0);
            chk($sformatf("seq_%0d", i), state, exp_seq[i]);
            chk($sformatf("seq_to_%0d", i), side_timeout, i == 19);
        end

        // Early sensor release on the second S3 cycle
        step(1'b0, 1'b1);
        repeat (19) step(1'b0, 1'b0);
        run_until(3, 1'b1, "early_reach_s3");
        step(1'b1, 1'b0);
        chk("early_s3_second", state, 3);
        step(1'b0, 1'b0);
        chk("early_s4", state, 4);
        chk("early_no_to", side_timeout, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("early_s4_last", farm, 1);
        step(1'b0, 1'b0);
        chk("early_back_s0", state, 0);

        // Sensor drop during all-red
        step(1'b0, 1'b1);
        run_until(2, 1'b1, "allred_reach_s2");
        n3 = 0; nto = 0;
        repeat (8) begin
            step(1'b0, 1'b0);
            if (state == 3'd3) n3++;
            if (side_timeout) nto++;
        end
        chk("allred_s3_len", n3, 1);
        chk("allred_no_to", nto, 0);
        chk("allred_back_s0", state, 0);

        // Reset while in S2, then while in S3 with x high
        for (int r = 2; r <= 3; r++) begin
            step(1'b0, 1'b1);
            run_until(r, 1'b1, $sformatf("rst_reach_s%0d", r));
            step(1'b1, 1'b1);
            chk("rst_state", state, 0);
            chk("rst_highway", highway, 2);
            chk("rst_farm", farm, 0);
            chk("rst_to", side_timeout, 0);
            n0 = 1;
            for (int i = 0; i < 20 && state == 3'd0; i++) begin
                step(1'b1, 1'b0);
                if (state == 3'd0) n0++;
            end
            chk("rst_s0_len", n0, 8);
        end

        // Randomized traffic with occasional clears
        xr = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) xr = ~xr;
            step(xr, $urandom_range(0, 79) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
